// File: rtl/drive_ready_monitor_pkg.sv
// drive_ready_monitor_pkg: shared state encoding and fault codes for the drive-ready monitor
package drive_ready_monitor_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PURGE = 2'd1,
    ST_READY = 2'd2,
    ST_FAULT = 2'd3
  } state_t;
  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_EARLY   = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;
  localparam logic [1:0] FC_DROP    = 2'd3;
endpackage

// File: rtl/mon_sync_debounce.sv
// mon_sync_debounce: 2-flop synchronizer for one bus line, with an optional
// microsecond-based debounce stage enabled by DRIVE_MON_DEBOUNCE_EN.
module mon_sync_debounce #(
  parameter int DEBOUNCE_US = 50
) (
  input  logic clock,
  input  logic reset,
  input  logic clkenbl_1usec_i,
  input  logic async_i,
  output logic level_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clock) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], async_i};
  end
`ifdef DRIVE_MON_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_US + 1);
  logic [CW-1:0] cnt_q;
  logic          level_q;
  // counter only runs while the synchronized level differs from the accepted one
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (sync_q[1] == level_q) begin
      cnt_q <= '0;
    end else if (clkenbl_1usec_i) begin
      if (cnt_q == CW'(DEBOUNCE_US - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
  assign level_o = level_q;
`else
  logic unused_en;
  assign unused_en = clkenbl_1usec_i & (DEBOUNCE_US != 0);
  assign level_o   = sync_q[1];
`endif
endmodule

// File: rtl/drive_ready_monitor.sv
// drive_ready_monitor: times the drive purge interval and reports ready/fault status.
// Optional input debounce is enabled by defining DRIVE_MON_DEBOUNCE_EN.
module drive_ready_monitor
  import drive_ready_monitor_pkg::*;
#(
  parameter int MIN_PURGE_MS = 85000,
  parameter int MAX_PURGE_MS = 95000,
  parameter int DEBOUNCE_US  = 50,
  parameter int MS_W         = 17
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clkenbl_1usec,
  input  logic            unlocked_l,
  input  logic            relay_l,
  input  logic            selected_h,
  input  logic            clear_fault,
  output logic            drive_ready,
  output logic            purging,
  output logic [MS_W-1:0] purge_ms,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic [7:0]      ready_drops
);
  localparam logic [MS_W-1:0] MIN_MS = MS_W'(MIN_PURGE_MS);
  localparam logic [MS_W-1:0] MAX_MS = MS_W'(MAX_PURGE_MS);
  logic unlocked_s, relay_s, selected_s;
  mon_sync_debounce #(.DEBOUNCE_US(DEBOUNCE_US)) u_unlocked (
    .clock(clock), .reset(reset), .clkenbl_1usec_i(clkenbl_1usec),
    .async_i(unlocked_l), .level_o(unlocked_s)
  );
  mon_sync_debounce #(.DEBOUNCE_US(DEBOUNCE_US)) u_relay (
    .clock(clock), .reset(reset), .clkenbl_1usec_i(clkenbl_1usec),
    .async_i(relay_l), .level_o(relay_s)
  );
  mon_sync_debounce #(.DEBOUNCE_US(DEBOUNCE_US)) u_selected (
    .clock(clock), .reset(reset), .clkenbl_1usec_i(clkenbl_1usec),
    .async_i(selected_h), .level_o(selected_s)
  );
  state_t          state_q, state_d;
  logic [9:0]      us_cnt_q, us_cnt_d;
  logic [MS_W-1:0] purge_ms_q, purge_ms_d;
  logic [1:0]      code_q, code_d, fault_code_q;
  logic [7:0]      drops_q, drops_d;
  logic            drive_ready_q, purging_q, fault_q;
  logic            ms_tick, ready_ok, dropped;
  assign ms_tick  = clkenbl_1usec && (us_cnt_q == 10'd999);
  assign ready_ok = !relay_s && selected_s;
  assign dropped  = !selected_s || relay_s;
  always_comb begin
    state_d    = state_q;
    purge_ms_d = purge_ms_q;
    code_d     = code_q;
    drops_d    = drops_q;
    us_cnt_d   = clkenbl_1usec ? (us_cnt_q == 10'd999 ? 10'd0 : us_cnt_q + 10'd1) : us_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (unlocked_s) begin
          state_d    = ST_PURGE;
          purge_ms_d = '0;
          us_cnt_d   = '0;
        end
      end
      ST_PURGE: begin
        if (!unlocked_s) begin
          state_d = ST_IDLE;
        end else if (ready_ok) begin
          state_d = (purge_ms_q >= MIN_MS) ? ST_READY : ST_FAULT;
          code_d  = (purge_ms_q >= MIN_MS) ? FC_NONE : FC_EARLY;
        end else if (purge_ms_q >= MAX_MS) begin
          state_d = ST_FAULT;
          code_d  = FC_TIMEOUT;
        end else if (ms_tick && !(&purge_ms_q)) begin
          purge_ms_d = purge_ms_q + 1'b1;
        end
      end
      ST_READY: begin
        if (dropped) begin
          drops_d = (&drops_q) ? drops_q : drops_q + 8'd1;
          state_d = unlocked_s ? ST_FAULT : ST_IDLE;
          code_d  = unlocked_s ? FC_DROP : FC_NONE;
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          state_d = ST_IDLE;
          code_d  = FC_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      us_cnt_q      <= '0;
      purge_ms_q    <= '0;
      code_q        <= FC_NONE;
      drops_q       <= '0;
      drive_ready_q <= 1'b0;
      purging_q     <= 1'b0;
      fault_q       <= 1'b0;
      fault_code_q  <= FC_NONE;
    end else begin
      state_q       <= state_d;
      us_cnt_q      <= us_cnt_d;
      purge_ms_q    <= purge_ms_d;
      code_q        <= code_d;
      drops_q       <= drops_d;
      drive_ready_q <= (state_q == ST_READY);
      purging_q     <= (state_q == ST_PURGE);
      fault_q       <= (state_q == ST_FAULT);
      fault_code_q  <= (state_q == ST_FAULT) ? code_q : FC_NONE;
    end
  end
  assign drive_ready = drive_ready_q;
  assign purging     = purging_q;
  assign purge_ms    = purge_ms_q;
  assign fault       = fault_q;
  assign fault_code  = fault_code_q;
  assign ready_drops = drops_q;
endmodule

// File: tb/tb_drive_ready_monitor.sv
// tb_drive_ready_monitor: directed plus randomized purge episodes checked against
// an outcome model derived from the purge-interval rules; 1 us enable on every clock.
module tb_drive_ready_monitor;
  localparam int MIN = 5;
  localparam int MAX = 10;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clkenbl_1usec = 1'b1;
  logic        unlocked_l = 1'b0;
  logic        relay_l = 1'b1;
  logic        selected_h = 1'b0;
  logic        clear_fault = 1'b0;
  logic        drive_ready, purging, fault;
  logic [16:0] purge_ms;
  logic [1:0]  fault_code;
  logic [7:0]  ready_drops;
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_drops = 0;
  int          rn;
  bit          seen;

  always #5 clock = ~clock;

  drive_ready_monitor #(
    .MIN_PURGE_MS(MIN), .MAX_PURGE_MS(MAX), .DEBOUNCE_US(3), .MS_W(17)
  ) dut (
    .clock(clock), .reset(reset), .clkenbl_1usec(clkenbl_1usec),
    .unlocked_l(unlocked_l), .relay_l(relay_l), .selected_h(selected_h),
    .clear_fault(clear_fault), .drive_ready(drive_ready), .purging(purging),
    .purge_ms(purge_ms), .fault(fault), .fault_code(fault_code),
    .ready_drops(ready_drops)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // 0 purging, 1 ready, 2 fault, 3 idle
  function automatic bit cond(input int w);
    case (w)
      0: return purging === 1'b1;
      1: return drive_ready === 1'b1;
      2: return fault === 1'b1;
      default: return drive_ready === 1'b0 && purging === 1'b0 && fault === 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int w, input int limit, input string tag);
    int k = 0;
    while (!cond(w) && k < limit) begin
      step(1);
      k++;
    end
    chk(tag, 32'(cond(w)), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(drive_ready), 0);
    chk({tag, "_purging"}, 32'(purging), 0);
    chk({tag, "_purge_ms"}, 32'(purge_ms), 0);
    chk({tag, "_fault"}, 32'(fault), 0);
    chk({tag, "_code"}, 32'(fault_code), 0);
    chk({tag, "_drops"}, 32'(ready_drops), 0);
  endtask

  // Ready lines applied n ms into the purge: below MIN is early, at/after MAX the timeout fires first.
  task automatic run_episode(input int n, input string tag);
    int code;
    int ms;
    code = (n < MIN) ? 1 : ((n < MAX) ? 0 : 2);
    ms   = (code == 2) ? MAX : n;
    unlocked_l = 1'b1;
    wait_until(0, 20, {tag, "_enter_purge"});
    if (code == 2) begin
      wait_until(2, MAX * 1000 + 100, {tag, "_timeout"});
    end else begin
      step(n * 1000);
      relay_l    = 1'b0;
      selected_h = 1'b1;
      wait_until(code == 0 ? 1 : 2, 20, {tag, "_outcome"});
    end
    step(1);
    chk({tag, "_ready"}, 32'(drive_ready), code == 0 ? 1 : 0);
    chk({tag, "_fault"}, 32'(fault), code == 0 ? 0 : 1);
    chk({tag, "_code"}, 32'(fault_code), 32'(code));
    chk({tag, "_purge_ms"}, 32'(purge_ms), 32'(ms));
    chk({tag, "_purging"}, 32'(purging), 0);
  endtask

  task automatic recover_fault(input string tag);
    unlocked_l = 1'b0;
    relay_l    = 1'b1;
    selected_h = 1'b0;
    step(10);
    chk({tag, "_fault_held"}, 32'(fault), 1);
    clear_fault = 1'b1;
    step(1);
    clear_fault = 1'b0;
    wait_until(3, 10, {tag, "_cleared"});
    chk({tag, "_code_cleared"}, 32'(fault_code), 0);
  endtask

  task automatic orderly_stop(input string tag);
    unlocked_l = 1'b0;
    step(10);
    chk({tag, "_still_ready"}, 32'(drive_ready), 1);
    relay_l    = 1'b1;
    selected_h = 1'b0;
    exp_drops++;
    wait_until(3, 20, {tag, "_idle"});
    chk({tag, "_no_fault"}, 32'(fault), 0);
    chk({tag, "_drops"}, 32'(ready_drops), 32'(exp_drops));
  endtask

  initial begin
    step(3);
    check_all_zero("reset");
    reset = 1'b0;
    step(10);
    check_all_zero("idle_after_reset");

    run_episode(7, "normal");
    clear_fault = 1'b1;
    step(1);
    clear_fault = 1'b0;
    step(3);
    chk("clear_ignored_in_ready", 32'(drive_ready), 1);
    selected_h = 1'b0;
    exp_drops++;
    wait_until(2, 20, "drop_fault");
    step(1);
    chk("drop_code", 32'(fault_code), 3);
    chk("drop_count", 32'(ready_drops), 32'(exp_drops));
    chk("drop_ready_low", 32'(drive_ready), 0);
    recover_fault("drop");

    run_episode(6, "second");
    orderly_stop("orderly");

    run_episode(2, "early");
    recover_fault("early");

    run_episode(MAX, "timeout");
    recover_fault("timeout");

    unlocked_l = 1'b1;
    wait_until(0, 20, "abort_enter");
    step(4000);
    chk("abort_purge_ms", 32'(purge_ms), 4);
    unlocked_l = 1'b0;
    wait_until(3, 20, "abort_idle");
    chk("abort_no_fault", 32'(fault), 0);

    repeat (3) begin
      rn = int'($urandom_range(0, MAX));
      run_episode(rn, "rand");
      if (rn >= MIN && rn < MAX) orderly_stop("rand");
      else recover_fault("rand");
    end

    run_episode(5, "pre_reset");
    reset = 1'b1;
    step(1);
    check_all_zero("reset_in_ready");
    unlocked_l = 1'b0;
    relay_l    = 1'b1;
    selected_h = 1'b0;
    step(5);
    reset = 1'b0;
    step(10);
    check_all_zero("idle_after_mid_reset");
    exp_drops = 0;

`ifdef DRIVE_MON_DEBOUNCE_EN
    unlocked_l = 1'b1;
    step(2);
    unlocked_l = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      seen |= purging;
    end
    chk("glitch_ignored", 32'(seen), 0);
    unlocked_l = 1'b1;
    step(3);
    unlocked_l = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      seen |= purging;
    end
    chk("stable_pulse_purge", 32'(seen), 1);
    step(20);
    chk("debounce_back_idle", 32'(cond(3)), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
